// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and line-level constants for the serial transmitter.
package serial_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: bit-period counter; tick marks the last clk of each period, held at zero while disabled.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    assign tick = enable && (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_cnt <= '0;
        else if (!enable || tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/serial_tx_sequencer.sv
// serial_tx_sequencer: frames words from an external LSB-first PISO into start/data/stop bits on tx_line.
module serial_tx_sequencer
    import serial_pkg::*;
#(
    parameter int WORD_LENGTH  = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tx_valid,
    input  logic [WORD_LENGTH-1:0] tx_data,
    output logic                   tx_ready,
    output logic [WORD_LENGTH-1:0] piso_data,
    output logic                   piso_load,
    output logic                   piso_shift,
    input  logic                   piso_serial,
    output logic                   tx_line,
    output logic                   busy,
    output logic                   done
);

    localparam int STOP_CYCLES = STOP_BITS * CLKS_PER_BIT;
    localparam int BW = $clog2(WORD_LENGTH + 1);
    localparam int SW = (STOP_CYCLES > 1) ? $clog2(STOP_CYCLES) : 1;

    tx_state_e     r_state;
    tx_state_e     w_next;
    logic          w_tick;
    logic          w_last_bit;
    logic          w_stop_end;
    logic [BW-1:0] r_bit_cnt;
    logic [SW-1:0] r_stop_cnt;

    baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk    (clk),
        .rst    (rst),
        .enable (r_state != IDLE),
        .tick   (w_tick)
    );

    assign w_last_bit = (r_bit_cnt == BW'(WORD_LENGTH - 1));
    assign w_stop_end = (r_stop_cnt == SW'(STOP_CYCLES - 1));
    assign piso_data  = tx_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  w_next = tx_valid ? START : IDLE;
            START: w_next = w_tick ? DATA : START;
            DATA:  w_next = (w_tick && w_last_bit) ? STOP : DATA;
            STOP:  w_next = w_stop_end ? IDLE : STOP;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        tx_ready   = (r_state == IDLE);
        busy       = !tx_ready;
        piso_load  = tx_ready && tx_valid;
        piso_shift = (r_state == DATA) && w_tick;
        done       = (r_state == STOP) && w_stop_end;
        tx_line    = (r_state == START) ? LINE_START :
                     (r_state == DATA)  ? piso_serial :
                     (r_state == STOP)  ? LINE_STOP : LINE_IDLE;
    end

    // The last data tick clears bit_cnt so STOP and the next frame start from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_bit_cnt <= '0;
        else if (r_state != DATA)
            r_bit_cnt <= '0;
        else if (w_tick)
            r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_stop_cnt <= '0;
        else if (r_state != STOP || w_stop_end)
            r_stop_cnt <= '0;
        else
            r_stop_cnt <= r_stop_cnt + 1'b1;
    end

endmodule
